// File: rtl/demux2_buf_pkg.sv
// Shared datapath definitions for the 1-to-2 demultiplexer and its 2:1 mux companion.
package demux2_buf_pkg;

    // Default datapath width for the RISC-V result path.
    localparam int WIDTH_DEF = 32;

    // Default per-output buffer depth.
    localparam int DEPTH_DEF = 2;

    // Output-select encoding, shared with the 2:1 select mux.
    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

    // Destination of a routed word.
    typedef enum logic {
        DEST_OUT0 = SEL_OUT0,
        DEST_OUT1 = SEL_OUT1
    } dest_e;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/demux2_buf_fifo.sv
// Per-destination FIFO with a registered head output.
// The head register mirrors the oldest entry while non-empty and keeps the
// last popped word once drained, so consumers see a stable value.
module demux_fifo
    import demux2_buf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_inc;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] head_reg;
    logic [WIDTH-1:0] head_next;
    logic             push_en;
    logic             pop_en;

    // Qualify requests: pushing a full FIFO or popping an empty one is a no-op.
    assign push_en    = push && !full;
    assign pop_en     = pop && !empty;
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(DEPTH));
    assign count     = count_reg;
    assign head_data = head_reg;

    // Storage: each entry written only when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Entry gi captures push data when it is the write target.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (push_en && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    // Next head value: the following entry after a pop, the incoming word when
    // the FIFO is (or becomes) empty, otherwise unchanged.
    always_comb begin
        head_next = head_reg;
        if (pop_en) begin
            if (count_reg > CW'(1)) begin
                head_next = mem_reg[rd_ptr_inc];
            end else if (push_en) begin
                head_next = push_data;
            end
        end else if (push_en && empty) begin
            head_next = push_data;
        end
    end

    // Occupancy moves by +1 on push, -1 on pop, unchanged when both happen.
    always_comb begin
        count_next = count_reg;
        if (push_en && !pop_en) begin
            count_next = count_reg + CW'(1);
        end else if (pop_en && !push_en) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Pointers, occupancy and head register; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            count_reg <= count_next;
            head_reg  <= head_next;
        end
    end

endmodule

// File: rtl/demux2_buf.sv
// Registered 1-to-2 demultiplexer: steers each accepted word into the FIFO
// named by in_sel and presents each FIFO head to its own consumer.
module demux2_buf
    import demux2_buf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out0_data,
    output logic                     out0_valid,
    input  logic                     out0_ready,
    output logic [$clog2(DEPTH):0]   out0_count,
    output logic [WIDTH-1:0]         out1_data,
    output logic                     out1_valid,
    input  logic                     out1_ready,
    output logic [$clog2(DEPTH):0]   out1_count
);

    localparam int CW = count_width(DEPTH);

    dest_e            dest;
    logic             accept;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       empty;
    logic [1:0]       full;
    logic [1:0]       cons_ready;
    logic [WIDTH-1:0] head [2];
    logic [CW-1:0]    cnt  [2];

    assign dest       = dest_e'(in_sel);
    assign cons_ready = {out1_ready, out0_ready};

    // Readiness depends only on the selected FIFO's registered fullness, so a
    // stalled consumer never back-pressures words bound for the other one.
    always_comb begin
        in_ready = 1'b1;
        case (dest)
            DEST_OUT0: in_ready = !full[0];
            DEST_OUT1: in_ready = !full[1];
            default:   in_ready = 1'b1;
        endcase
    end

    assign accept = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_out
            // Route the accepted word to the addressed FIFO; pop on consumer take.
            assign push[gi] = accept && (in_sel == 1'(gi));
            assign pop[gi]  = cons_ready[gi] && !empty[gi];

            demux_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (push[gi]),
                .push_data (in_data),
                .pop       (pop[gi]),
                .head_data (head[gi]),
                .empty     (empty[gi]),
                .full      (full[gi]),
                .count     (cnt[gi])
            );
        end
    endgenerate

    assign out0_data  = head[0];
    assign out0_valid = !empty[0];
    assign out0_count = cnt[0];
    assign out1_data  = head[1];
    assign out1_valid = !empty[1];
    assign out1_count = cnt[1];

endmodule

// File: tb/tb_demux2_buf.sv
// Self-checking bench for demux2_buf: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_demux2_buf;

    localparam int W  = 32;
    localparam int D  = 2;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_sel = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  out0_data, out1_data;
    logic          out0_valid, out1_valid;
    logic          out0_ready = 1'b0, out1_ready = 1'b0;
    logic [CW-1:0] out0_count, out1_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one queue per destination plus the last popped word.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] last0 = '0;
    logic [W-1:0] last1 = '0;
    logic         last_acc = 1'b1;

    demux2_buf #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_count (out0_count),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_count (out1_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
    endtask

    task automatic check_outputs();
        check("out0_valid", 64'(out0_valid), 64'(q0.size() > 0));
        check("out0_data",  64'(out0_data),  64'((q0.size() > 0) ? q0[0] : last0));
        check("out0_count", 64'(out0_count), 64'(q0.size()));
        check("out1_valid", 64'(out1_valid), 64'(q1.size() > 0));
        check("out1_data",  64'(out1_data),  64'((q1.size() > 0) ? q1[0] : last1));
        check("out1_count", 64'(out1_count), 64'(q1.size()));
    endtask

    // One clock of traffic: drive at the falling edge, check ready, apply the
    // model's effect of the coming rising edge, then check at the next fall.
    task automatic step(input logic v, input logic sel, input logic [W-1:0] d,
                        input logic r0, input logic r1);
        logic exp_rdy, acc, p0, p1;
        in_valid = v; in_sel = sel; in_data = d; out0_ready = r0; out1_ready = r1;
        #1;
        exp_rdy = sel ? (q1.size() < D) : (q0.size() < D);
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        acc = v && exp_rdy;
        p0  = r0 && (q0.size() > 0);
        p1  = r1 && (q1.size() > 0);
        if (p0) last0 = q0.pop_front();
        if (p1) last1 = q1.pop_front();
        if (acc) begin
            if (sel) q1.push_back(d);
            else     q0.push_back(d);
        end
        last_acc = acc;
        $display("t=%0t v=%b sel=%b d=%h acc=%b pop0=%b pop1=%b cnt=%0d/%0d",
                 $time, v, sel, d, acc, p0, p1, q0.size(), q1.size());
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * D + 2; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        check("drained", 64'({out0_valid, out1_valid}), 64'(0));
    endtask

    initial begin
        logic [W-1:0] word;
        logic         v, sel;
        int           sent;

        // Reset held for two cycles, released at a falling edge.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs();
        check("rst_in_ready_sel0", 64'(in_ready), 64'(1));
        in_sel = 1'b1; #1;
        check("rst_in_ready_sel1", 64'(in_ready), 64'(1));
        @(negedge clk);

        // Routing to each output with both consumers stalled.
        step(1'b1, 1'b0, 32'h0F0F0F0F, 1'b0, 1'b0);
        check("route_out1_untouched", 64'(out1_valid), 64'(0));
        step(1'b1, 1'b1, 32'hF0F0F0F0, 1'b0, 1'b0);
        check("route_out0_data", 64'(out0_data), 64'h0F0F0F0F);
        check("route_out1_data", 64'(out1_data), 64'hF0F0F0F0);
        check("route_counts", 64'({out0_count, out1_count}), 64'({CW'(1), CW'(1)}));
        drain();

        // Backpressure on a full FIFO 0 while FIFO 1 keeps accepting.
        step(1'b1, 1'b0, 32'h1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h2, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h3, 1'b0, 1'b0);
        check("full_count0", 64'(out0_count), 64'(2));
        step(1'b1, 1'b1, 32'h3, 1'b0, 1'b0);
        check("full_other_out1", 64'(out1_data), 64'h3);
        step(1'b1, 1'b0, 32'h4, 1'b1, 1'b0);   // pop edge: still not ready this cycle
        check("full_pop_head", 64'(out0_data), 64'h2);
        step(1'b1, 1'b0, 32'h4, 1'b0, 1'b0);   // ready again the following cycle
        check("full_reaccept", 64'(last_acc), 64'(1));
        drain();

        // Simultaneous push/pop with one entry, then a sustained stream.
        step(1'b1, 1'b0, 32'hA, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'hB, 1'b1, 1'b0);
        check("pushpop_count", 64'(out0_count), 64'(1));
        check("pushpop_head", 64'(out0_data), 64'hB);
        for (int i = 'h10; i <= 'h1F; i++) begin
            step(1'b1, 1'b0, W'(i), 1'b1, 1'b0);
            check("stream_head", 64'(out0_data), 64'(i));
        end
        drain();

        // Wrap-around: 5*DEPTH words through out1 with random consumer stalls.
        sent = 0;
        word = 32'h100;
        for (int i = 0; i < 300 && sent < 5 * D; i++) begin
            step(1'b1, 1'b1, word, 1'b0, 1'($urandom_range(0, 1)));
            check("wrap_bound", 64'(out1_count <= CW'(D)), 64'(1));
            if (last_acc) begin
                sent++;
                word = word + 1;
            end
        end
        check("wrap_all_sent", 64'(sent), 64'(5 * D));
        drain();

        // Random mixed traffic, honouring the hold-while-stalled rule.
        v = 1'b0; sel = 1'b0; word = '0;
        for (int i = 0; i < 200; i++) begin
            if (!(v && !last_acc)) begin
                v    = 1'($urandom_range(0, 3) != 0);
                sel  = 1'($urandom_range(0, 1));
                word = $urandom;
            end
            step(v, sel, word, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
        end
        drain();

        // Asynchronous reset between edges with FIFO 0 full.
        step(1'b1, 1'b0, 32'hDEAD0001, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'hDEAD0002, 1'b0, 1'b0);
        check("pre_reset_count0", 64'(out0_count), 64'(2));
        in_valid = 1'b0; in_sel = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("async_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check("no_stale0", 64'(out0_data[31:16] == 16'hDEAD), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux2_buf.md
# demux2_buf

Registered 1-to-2 demultiplexer with valid/ready handshaking and a small FIFO per destination. It is the companion of the 2:1 select mux. The mux merges two 32-bit sources into one under a select bit. This block takes one 32-bit source plus a select bit and steers each accepted word to output 0 or output 1, buffering it until that consumer takes it. It sits between a single producer (e.g. ALU/load result) and two independent consumers in the RISC-V datapath.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 2, entries per output FIFO; power of two, ≥ 2
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_data  input  WIDTH  word to route
- in_sel  input  1  destination: 0 → out0, 1 → out1
- in_valid  input  1  producer offers in_data/in_sel this cycle
- in_ready  output  1  block accepts this cycle
- out0_data / out1_data  output  WIDTH  head entry of FIFO 0 / 1
- out0_valid / out1_valid  output  1  FIFO 0 / 1 non-empty
- out0_ready / out1_ready  input  1  consumer 0 / 1 takes head this cycle
- out0_count / out1_count  output  $clog2(DEPTH)+1  occupancy of FIFO 0 / 1

## Operation
- Transfer in: in_valid && in_ready at a rising edge; the word is pushed into FIFO[in_sel].
- in_ready = !full[in_sel]. It is combinational from in_sel and registered occupancy only, and never depends on outN_ready.
- Transfer out N: outN_valid && outN_ready at an edge pops FIFO N; head advances.
- Pop while empty: ignored, no state change.
- Push and pop on the same FIFO in the same cycle (FIFO not full): count unchanged, order preserved.
- Push to one FIFO and pop of the other in the same cycle: both take effect independently.
- Word order is FIFO within each output. There is no ordering guarantee across outputs.
- A full FIFO blocks only words selected for it. A word for the other output is accepted whenever that FIFO has space.
- in_data/in_sel are don't-care when in_valid = 0. Producer must hold in_data/in_sel stable while in_valid && !in_ready.
- outN_data equals the head entry when outN_valid = 1. It is 0 when the FIFO has been empty since reset; otherwise it holds the last popped value.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.

## Timing
- Reset (rst_n low, asynchronous, any cycle including mid-transfer): all entries, pointers, and counts go to 0. out0_valid = out1_valid = 0. out0_data = out1_data = 0. out0_count = out1_count = 0. in_ready = 1. In-flight words are discarded.
- After rst_n deasserts, the first accepting edge is the first rising clk edge with rst_n high.
- Latency: a word accepted at edge k is visible on outN_data with outN_valid = 1 from edge k (registered output, one cycle) and can be popped at edge k+1.
- Throughput: one word per cycle sustained into each FIFO while its consumer holds ready high.
- Full: count = DEPTH means in_ready = 0 for that sel. The edge that pops the full FIFO makes in_ready high for the following cycle, not the same cycle.

## Structure
- WIDTH default and the out-select encoding (SEL_OUT0 = 0, SEL_OUT1 = 1) go in the shared RISC-V defines header used by the mux.
- Sub-module demux_fifo (WIDTH, DEPTH):
  - ports: clk, rst_n, push, push_data, pop, head_data, empty, full, count
  - instantiated twice; top level holds only sel decode and handshake logic.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles. Then both outN_valid = 0, both counts = 0, both outN_data = 0, in_ready = 1.
- Routing:
  - push 0x0F0F0F0F with sel 0, then 0xF0F0F0F0 with sel 1, both consumers ready = 0
  - out0_data = 0x0F0F0F0F, out1_data = 0xF0F0F0F0, counts 1/1
  - out1 never sees the sel-0 word.
- Full/backpressure (DEPTH = 2), out0_ready = 0:
  - push 0x1, 0x2 to out0, then offer 0x3 with sel 0: in_ready = 0, count0 stays 2
  - switch sel to 1: in_ready = 1, 0x3 lands in out1
  - raise out0_ready for one cycle: pops 0x1, out0_data = 0x2, in_ready for sel 0 goes high the next cycle.
- Simultaneous push/pop on FIFO 0 with count 1 (head 0xA, push 0xB):
  - count stays 1, out0_data = 0xB
  - a continuous stream 0x10..0x1F with out0_ready = 1 exits in order, one word per cycle.
- Wrap-around: push/pop 5·DEPTH words through out1 with random out1_ready stalls. Output sequence matches input order exactly; count never exceeds DEPTH.
- Async reset mid-operation: assert rst_n low between edges with count0 = 2. Outputs go to reset values immediately without waiting for the next clk edge; the old words never appear afterward.
